// File: rtl/bin_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per ADJ+SHF pair.
// Latency: 2*tamanyo+1 edges from accepted Start to the Done pulse.
// Backpressure: none; Start is only sampled in IDLE, so a Start while Busy is dropped.
module bin_a_bcd_secuencial #(
    parameter int tamanyo = 32,
    parameter int DIGITS  = 10
) (
    input  logic                  CLK,
    input  logic                  RSTa,
    input  logic                  Start,
    input  logic [tamanyo-1:0]    Bin,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Busy,
    output logic                  Done
);

    localparam int CW = (tamanyo > 1) ? $clog2(tamanyo) : 1;
    localparam int AW = 4 * DIGITS;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADJ  = 2'd1;
    localparam logic [1:0] SHF  = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]         state;
    logic [tamanyo-1:0] sr;
    logic [AW-1:0]      acc;
    logic [AW-1:0]      acc_adj;
    logic [CW-1:0]      cnt;

    // Nibbles are corrected independently; a corrected nibble never exceeds 12, so no carry out.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            BCD   <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        sr    <= Bin;
                        acc   <= '0;
                        cnt   <= CW'(tamanyo - 1);
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    acc   <= acc_adj;
                    state <= SHF;
                end
                SHF: begin
                    acc <= {acc[AW-2:0], sr[tamanyo-1]};
                    sr  <= sr << 1;
                    if (cnt == '0) begin
                        state <= FIN;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= ADJ;
                    end
                end
                FIN: begin
                    BCD   <= acc;
                    Done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// Bench for bin_a_bcd_secuencial: default 32-bit/10-digit instance plus an 8-bit/3-digit override,
// expected digits derived by repeated division by ten and checked by a Done-driven monitor.
module tb_bin_a_bcd_secuencial;

    logic        CLK = 1'b0;
    logic        RSTa = 1'b0;
    logic        start_a = 1'b0;
    logic [31:0] bin_a = '0;
    logic [39:0] bcd_a;
    logic        busy_a, done_a;
    logic        start_b = 1'b0;
    logic [7:0]  bin_b = '0;
    logic [11:0] bcd_b;
    logic        busy_b, done_b;

    bin_a_bcd_secuencial dut_a (
        .CLK(CLK), .RSTa(RSTa), .Start(start_a), .Bin(bin_a),
        .BCD(bcd_a), .Busy(busy_a), .Done(done_a)
    );

    bin_a_bcd_secuencial #(.tamanyo(8), .DIGITS(3)) dut_b (
        .CLK(CLK), .RSTa(RSTa), .Start(start_b), .Bin(bin_b),
        .BCD(bcd_b), .Busy(busy_b), .Done(done_b)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [39:0] bcd;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [39:0] ref_bcd(input longint unsigned v, input int digits);
        logic [39:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(negedge CLK) begin
        if (done_a) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_a_unexpected: got Done with BCD %h, expected no Done", bcd_a);
            end else begin
                ea = q_a.pop_front();
                check("bcd_a", bcd_a, ea.bcd);
                check("latency_a", 40'(cyc), 40'(ea.due));
                check("busy_in_done_a", {39'd0, busy_a}, 40'd0);
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_b_unexpected: got Done with BCD %h, expected no Done", bcd_b);
            end else begin
                eb = q_b.pop_front();
                check("bcd_b", {28'd0, bcd_b}, eb.bcd);
                check("latency_b", 40'(cyc), 40'(eb.due));
                check("busy_in_done_b", {39'd0, busy_b}, 40'd0);
            end
        end
    end

    // Called just after a rising edge; Start is presented for exactly one edge once idle.
    task automatic go_a(input logic [31:0] v, input bit track);
        int w;
        w = 0;
        while (busy_a && w < 200) begin
            @(posedge CLK); #1;
            w++;
        end
        if (busy_a) flag("busy_a_timeout");
        start_a = 1'b1;
        bin_a   = v;
        @(posedge CLK); #1;
        if (track) q_a.push_back('{ref_bcd(64'(v), 10), cyc + 65});
        start_a = 1'b0;
        bin_a   = $urandom;
    endtask

    task automatic go_b(input logic [7:0] v);
        int w;
        w = 0;
        while (busy_b && w < 100) begin
            @(posedge CLK); #1;
            w++;
        end
        if (busy_b) flag("busy_b_timeout");
        start_b = 1'b1;
        bin_b   = v;
        @(posedge CLK); #1;
        q_b.push_back('{ref_bcd(64'(v), 3), cyc + 17});
        start_b = 1'b0;
        bin_b   = 8'($urandom);
    endtask

    initial begin
        int w;
        RSTa = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_bcd_a", bcd_a, 40'd0);
        check("reset_busy_a", {39'd0, busy_a}, 40'd0);
        check("reset_done_a", {39'd0, done_a}, 40'd0);
        check("reset_bcd_b", {28'd0, bcd_b}, 40'd0);
        RSTa = 1'b1;
        @(posedge CLK); #1;

        go_a(32'd0, 1'b1);
        go_a(32'd4294967295, 1'b1);
        go_a(32'd1234567890, 1'b1);
        go_a(32'd9, 1'b1);
        go_a(32'd100, 1'b1);
        go_a(32'd65535, 1'b1);

        // Second Start during a conversion must be ignored.
        go_a(32'd42, 1'b1);
        repeat (10) @(posedge CLK);
        #1;
        start_a = 1'b1;
        bin_a   = 32'd7;
        @(posedge CLK); #1;
        start_a = 1'b0;
        check("busy_during_conv", {39'd0, busy_a}, 40'd1);

        // Reset 20 cycles into a conversion aborts it silently.
        go_a(32'd999, 1'b0);
        repeat (20) @(posedge CLK);
        #1;
        RSTa = 1'b0;
        @(posedge CLK); #1;
        RSTa = 1'b1;
        check("abort_busy", {39'd0, busy_a}, 40'd0);
        check("abort_bcd", bcd_a, 40'd0);
        repeat (80) @(posedge CLK);
        #1;
        check("abort_bcd_hold", bcd_a, 40'd0);
        go_a(32'd58, 1'b1);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] v;
            v = (i % 3 == 0) ? 32'($urandom_range(0, 9999)) : 32'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge CLK);
            #1;
            go_a(v, 1'b1);
        end

        go_b(8'd255);
        go_b(8'd28);
        go_b(8'd0);
        for (int i = 0; i < 8; i++) go_b(8'($urandom));

        w = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && w < 500) begin
            @(posedge CLK); #1;
            w++;
        end
        check("pending_a", 40'(q_a.size()), 40'd0);
        check("pending_b", 40'(q_b.size()), 40'd0);
        repeat (5) @(posedge CLK);
        #1;
        check("final_bcd_b_hold", {28'd0, bcd_b}, 40'(eb.bcd));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_a_bcd_secuencial.md
Name: bin_a_bcd_secuencial

Overview:
Sequential binary-to-BCD converter (shift-add-3 / double-dabble) directly downstream of the algorithmic divider. It consumes the divider's quotient or remainder when the divider flags completion. It produces packed BCD digits for the display / reporting stage. One bit is processed per two clock cycles, using the same start/done handshake style as the divider.

Parameters:
tamanyo, 32, width of binary input; must match the divider's tamanyo.
DIGITS, 10, number of BCD output digits; 10 covers 2^32-1. If 10^DIGITS <= 2^tamanyo-1, the most significant digits are silently truncated.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RSTa  input  1  reset; synchronous, active-low, sampled on the CLK rising edge.
Start  input  1  request; sampled only in IDLE; normally tied to divider Done.
Bin  input  tamanyo  unsigned binary value; sampled on the same edge as an accepted Start.
BCD  output  4*DIGITS  packed BCD result; digit 0 (units) in BCD[3:0].
Busy  output  1  high whenever state != IDLE.
Done  output  1  one-cycle completion pulse; BCD is valid from this cycle.

Behaviour:
- Reset (RSTa==0 at a rising edge): state=IDLE, BCD=0, Done=0, Busy=0, internal shift register, accumulator and counter all cleared.
- Reset asserted mid-conversion aborts it with no Done pulse; BCD returns to 0.
- Internal registers:
  - SR: tamanyo bits, binary shift register.
  - ACC: 4*DIGITS bits, BCD accumulator.
  - CNT: clog2(tamanyo) bits.
- IDLE:
  - Start==1: SR<=Bin, ACC<=0, CNT<=tamanyo-1, next=ADJ.
  - Otherwise stay in IDLE.
- ADJ: every 4-bit nibble of ACC that is >=5 gets +3 (all nibbles in parallel, no carry between nibbles); next=SHF.
- SHF: {ACC,SR}<={ACC,SR}<<1 (MSB of SR enters ACC bit 0; bit shifted out of ACC top is discarded).
  - CNT==0: next=FIN.
  - Otherwise CNT<=CNT-1, next=ADJ.
- FIN: BCD<=ACC, Done<=1, next=IDLE.
- Done is registered. It is high for exactly one cycle after the FIN edge and is cleared on the following edge.
- Latency: Start accepted at edge E0 means ADJ/SHF occupy edges E1..E2T (T=tamanyo), FIN at E2T+1, Done high between E2T+1 and E2T+2. For T=32 that is 65 edges from Start to Done.
- Busy: high from E1 through the FIN cycle; low in the Done cycle, so Start may be accepted in that same cycle (back-to-back conversions allowed).
- Start while Busy: ignored, no queuing, Bin not re-sampled.
- BCD holds its last value between conversions and only changes at FIN or reset.
- Bin may change freely after the accepting edge.
- Every output digit is always in the range 0..9 for in-range inputs.
- Unused state encoding returns to IDLE on the next edge.

Test Plan:
- Reset, then Start with Bin=0 -> Done exactly 65 cycles after Start; BCD=0x0000000000; Busy low in the Done cycle.
- Bin=4294967295 -> BCD=0x4294967295; Bin=1234567890 -> BCD=0x1234567890; Bin=9 -> BCD=0x0000000009.
- Two conversions back-to-back (second Start in the Done cycle of the first) with Bin=100 then Bin=65535 -> BCD=0x0000000100 then 0x0000065535, Done pulses 65 cycles apart.
- Start re-asserted with Bin=7 during a conversion of Bin=42 -> second Start ignored; single Done with BCD=0x0000000042.
- RSTa low for one edge 20 cycles into a conversion -> Busy=0, BCD=0, no Done; a fresh Start with Bin=58 gives BCD=0x0000000058.
- Parameter override tamanyo=8, DIGITS=3: Bin=255 -> BCD=0x255 after 17 cycles; chained from the divider with Num=200, Den=7 -> quotient 28 converts to 0x028.
